// File: rtl/endec_axis_pkg.sv
// Shared types and sizing helpers for the AXI-Stream frame serialiser/deserialiser.
// Beat counts round up so a partial final beat still gets its own transfer.
package endec_axis_pkg;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_DROP    = 1'b1
  } rx_state_t;

  function automatic int beat_count(input int frame_w, input int data_w);
    return (frame_w + data_w - 1) / data_w;
  endfunction

  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/axis_frame_des.sv
// Slave-stream deserialiser: assembles RX_BEATS beats into a frame and
// flags packets whose tlast does not land on the final beat.
module axis_frame_des
  import endec_axis_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int RX_FRAME_W = 704
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [RX_FRAME_W-1:0] rx_frame,
  output logic                  rx_frame_valid,
  output logic                  rx_len_err
);

  localparam int RX_BEATS = beat_count(RX_FRAME_W, DATA_W);
  localparam int RX_IW    = idx_width(RX_BEATS);
  localparam int RX_PAD_W = RX_BEATS * DATA_W;
  localparam logic [RX_IW-1:0] RX_LAST = RX_IW'(RX_BEATS - 1);

  rx_state_t           rx_state;
  logic [RX_IW-1:0]    rx_idx;
  logic [RX_PAD_W-1:0] stage;
  logic [RX_PAD_W-1:0] stage_next;
  logic                rx_live;
  logic                rx_hs;

  assign s_axis_tready = rx_live;
  assign rx_hs         = s_axis_tvalid & rx_live;

  // Staging with the current beat merged in, so the final beat reaches rx_frame directly.
  always_comb begin
    stage_next = stage;
    stage_next[rx_idx*DATA_W +: DATA_W] = s_axis_tdata;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rx_state       <= RX_COLLECT;
      rx_idx         <= '0;
      stage          <= '0;
      rx_frame       <= '0;
      rx_frame_valid <= 1'b0;
      rx_len_err     <= 1'b0;
      rx_live        <= 1'b0;
    end else begin
      rx_live        <= 1'b1;
      rx_frame_valid <= 1'b0;
      rx_len_err     <= 1'b0;
      if (rx_hs) begin
        case (rx_state)
          RX_COLLECT: begin
            stage <= stage_next;
            if (s_axis_tlast) begin
              rx_idx <= '0;
              if (rx_idx == RX_LAST) begin
                rx_frame       <= stage_next[RX_FRAME_W-1:0];
                rx_frame_valid <= 1'b1;
              end else begin
                rx_len_err <= 1'b1;
              end
            end else if (rx_idx == RX_LAST) begin
              rx_state <= RX_DROP;
              rx_idx   <= '0;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end
          RX_DROP: begin
            if (s_axis_tlast) begin
              rx_len_err <= 1'b1;
              rx_state   <= RX_COLLECT;
            end
          end
          default: rx_state <= RX_COLLECT;
        endcase
      end
    end
  end

endmodule

// File: rtl/axis_frame_serdes.sv
// Frame-to-stream serialiser (TX, local) paired with the stream-to-frame
// deserialiser (RX, axis_frame_des); the two paths share only clock and reset.
module axis_frame_serdes
  import endec_axis_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int TX_FRAME_W = 640,
  parameter int RX_FRAME_W = 704
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [TX_FRAME_W-1:0] tx_frame,
  input  logic                  tx_frame_valid,
  output logic                  tx_frame_ready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [RX_FRAME_W-1:0] rx_frame,
  output logic                  rx_frame_valid,
  output logic                  rx_len_err
);

  localparam int TX_BEATS = beat_count(TX_FRAME_W, DATA_W);
  localparam int TX_IW    = idx_width(TX_BEATS);
  localparam int TX_PAD_W = TX_BEATS * DATA_W;
  localparam logic [TX_IW-1:0] TX_LAST = TX_IW'(TX_BEATS - 1);

  tx_state_t           tx_state;
  logic [TX_IW-1:0]    tx_idx;
  logic [TX_PAD_W-1:0] tx_buf;
  logic                tx_live;

  // tx_live holds ready low through reset and the release cycle.
  assign tx_frame_ready = tx_live && (tx_state == TX_IDLE);
  assign m_axis_tvalid  = (tx_state == TX_SEND);
  assign m_axis_tlast   = (tx_state == TX_SEND) && (tx_idx == TX_LAST);
  assign m_axis_tdata   = tx_buf[tx_idx*DATA_W +: DATA_W];

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_idx   <= '0;
      tx_buf   <= '0;
      tx_live  <= 1'b0;
    end else begin
      tx_live <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (tx_live && tx_frame_valid) begin
            tx_buf   <= TX_PAD_W'(tx_frame);
            tx_idx   <= '0;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (m_axis_tready) begin
            if (tx_idx == TX_LAST) begin
              tx_idx   <= '0;
              tx_state <= TX_IDLE;
            end else begin
              tx_idx <= tx_idx + 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  axis_frame_des #(
    .DATA_W     (DATA_W),
    .RX_FRAME_W (RX_FRAME_W)
  ) u_des (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .rx_frame       (rx_frame),
    .rx_frame_valid (rx_frame_valid),
    .rx_len_err     (rx_len_err)
  );

endmodule
